// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, fill owners
// and the address masks used to align fills and writes.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam logic [15:0] BLK_OFFSET_MASK = 16'hFFF0;
   localparam logic [15:0] HALF_ALIGN_MASK = 16'hFFFE;

endpackage

// File: rtl/mem_arbiter_fill_seq.sv
// Block fill sequencer: issues one read per cycle across the block, tracks
// reads in flight and counts returned words for the owning cache.
module block_fill_seq #(
   parameter int MEM_LAT   = 4,
   parameter int BLK_WORDS = 8,
   localparam int WORD_W   = $clog2(BLK_WORDS),
   localparam int ISSUE_W  = WORD_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              active,
   input  logic [15:0]       base,
   input  logic              mem_valid,
   output logic              issue_en,
   output logic [15:0]       issue_addr,
   output logic              accept,
   output logic [WORD_W-1:0] fill_word,
   output logic              last_word
);

   logic [ISSUE_W-1:0] issue_cnt_reg;
   logic [WORD_W-1:0]  recv_cnt_reg;
   // One bit per cycle of read latency; the top bit marks a word due back now,
   // so stray mem_valid pulses are never counted as fill data.
   logic [MEM_LAT-1:0] inflight_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt_reg <= '0;
         recv_cnt_reg  <= '0;
         inflight_reg  <= '0;
      end else if (!active) begin
         issue_cnt_reg <= '0;
         recv_cnt_reg  <= '0;
         inflight_reg  <= '0;
      end else begin
         if (issue_en)
            issue_cnt_reg <= issue_cnt_reg + ISSUE_W'(1);
         if (accept)
            recv_cnt_reg <= recv_cnt_reg + WORD_W'(1);
         inflight_reg <= (inflight_reg << 1) | MEM_LAT'(issue_en);
      end
   end

   assign issue_en   = active && (issue_cnt_reg < ISSUE_W'(BLK_WORDS));
   assign issue_addr = base + 16'({issue_cnt_reg, 1'b0});
   assign accept     = active && mem_valid && inflight_reg[MEM_LAT-1];
   assign fill_word  = recv_cnt_reg;
   assign last_word  = accept && (recv_cnt_reg == WORD_W'(BLK_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates main memory between I-cache fills, D-cache fills and D-cache
// write-through stores. Optional MEM_ARB_STATS_EN adds saturating done counters.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT   = 4,
   parameter int BLK_WORDS = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_req,
   input  logic [15:0]                  i_addr,
   output logic                         i_fill_we,
   output logic                         i_done,
   input  logic                         d_rd_req,
   input  logic                         d_wr_req,
   input  logic [15:0]                  d_addr,
   input  logic [15:0]                  d_wdata,
   output logic                         d_fill_we,
   output logic                         d_done,
   output logic [$clog2(BLK_WORDS)-1:0] fill_word,
   output logic [15:0]                  fill_data,
   output logic                         mem_en,
   output logic                         mem_wr,
   output logic [15:0]                  mem_addr,
   output logic [15:0]                  mem_wdata,
   input  logic [15:0]                  mem_rdata,
   input  logic                         mem_valid
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0]                  i_fill_cnt,
   output logic [15:0]                  d_fill_cnt,
   output logic [15:0]                  d_wr_cnt
`endif
);

   arb_state_t state_reg, state_next;
   owner_t     owner_reg, grant_owner;
   logic [15:0] addr_reg, grant_addr, wdata_reg;
   logic        grant;

   logic        issue_en, accept, last_word;
   logic [15:0] issue_addr;
   logic [$clog2(BLK_WORDS)-1:0] seq_word;

   block_fill_seq #(
      .MEM_LAT   (MEM_LAT),
      .BLK_WORDS (BLK_WORDS)
   ) u_fill_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .active     (state_reg == FILL),
      .base       (addr_reg),
      .mem_valid  (mem_valid),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .accept     (accept),
      .fill_word  (seq_word),
      .last_word  (last_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         owner_reg <= OWN_I;
         addr_reg  <= '0;
         wdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (grant) begin
            owner_reg <= grant_owner;
            addr_reg  <= grant_addr;
            wdata_reg <= d_wdata;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      grant       = 1'b0;
      grant_owner = OWN_I;
      grant_addr  = '0;
      i_fill_we   = 1'b0;
      d_fill_we   = 1'b0;
      i_done      = 1'b0;
      d_done      = 1'b0;
      fill_word   = '0;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      case (state_reg)
         IDLE: begin
            // Stores win so write-through data never waits behind a fill.
            if (d_wr_req) begin
               state_next  = WRITE;
               grant       = 1'b1;
               grant_owner = OWN_D;
               grant_addr  = d_addr & HALF_ALIGN_MASK;
            end else if (d_rd_req) begin
               state_next  = FILL;
               grant       = 1'b1;
               grant_owner = OWN_D;
               grant_addr  = d_addr & BLK_OFFSET_MASK;
            end else if (i_req) begin
               state_next  = FILL;
               grant       = 1'b1;
               grant_owner = OWN_I;
               grant_addr  = i_addr & BLK_OFFSET_MASK;
            end
         end
         FILL: begin
            mem_en   = issue_en;
            mem_addr = issue_en ? issue_addr : 16'h0000;
            if (accept) begin
               fill_word = seq_word;
               i_fill_we = (owner_reg == OWN_I);
               d_fill_we = (owner_reg == OWN_D);
               i_done    = last_word && (owner_reg == OWN_I);
               d_done    = last_word && (owner_reg == OWN_D);
            end
            if (last_word)
               state_next = IDLE;
         end
         WRITE: begin
            mem_en     = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = addr_reg;
            mem_wdata  = wdata_reg;
            d_done     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign fill_data = mem_rdata;

`ifdef MEM_ARB_STATS_EN
   logic [2:0] stat_evt;
   assign stat_evt = {i_done,
                      d_done && (state_reg == FILL),
                      d_done && (state_reg == WRITE)};

   for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      logic [15:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            cnt_reg <= '0;
         else if (stat_evt[gi] && (cnt_reg != 16'hFFFF))
            cnt_reg <= cnt_reg + 16'd1;
      end
   end

   assign i_fill_cnt = g_stat[2].cnt_reg;
   assign d_fill_cnt = g_stat[1].cnt_reg;
   assign d_wr_cnt   = g_stat[0].cnt_reg;
`endif

endmodule
